// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register sequencer: FSM states,
// response error codes, per-step byte command encoding.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STOP_ISSUE,
        STOP_WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_ARB     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [1:0] STEP_ADDR  = 2'd0;
    localparam logic [1:0] STEP_REG   = 2'd1;
    // Write: data byte + STOP. Read: repeated START + address/R.
    localparam logic [1:0] STEP_XFER  = 2'd2;
    localparam logic [1:0] STEP_READ  = 2'd3;
    localparam logic [1:0] WRITE_LAST = 2'd2;
    localparam logic [1:0] READ_LAST  = 2'd3;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       start;
        logic       stop;
        logic       nack;
        logic [7:0] data;
    } cmd_t;

    localparam cmd_t CMD_NONE = '0;

    function automatic logic [1:0] last_step(input logic rnw);
        return rnw ? READ_LAST : WRITE_LAST;
    endfunction

endpackage

// File: rtl/i2c_seq_timeout.sv
// Saturating cycle counter that flags when a byte command has waited
// TIMEOUT_CYCLES cycles; TIMEOUT_CYCLES = 0 never expires.
module i2c_seq_timeout #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [15:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count_q <= '0;
        end else if (i_enable && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign o_expire = i_enable && (TIMEOUT_CYCLES != 16'd0)
                   && (count_q == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write request into the sequence of byte commands
// for the single-byte I2C master and reports completion, read data and errors.
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_rnw,
    input  logic [6:0] i_req_slave_addr,
    input  logic [7:0] i_req_reg_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic [1:0] o_rsp_err,
    output logic       o_cmd_wr,
    output logic       o_cmd_rd,
    output logic       o_cmd_start,
    output logic       o_cmd_stop,
    output logic       o_cmd_nack,
    output logic [7:0] o_cmd_byte,
    input  logic       i_cmd_done,
    input  logic       i_cmd_slave_nack,
    input  logic       i_cmd_arb_lost,
    input  logic [7:0] i_cmd_rd_byte,
    output logic       o_bus_abort
);

    state_t     state_q, state_n;
    logic [1:0] step_q, step_n;
    err_t       err_q, err_n;
    logic       rnw_q;
    logic [6:0] slave_q;
    logic [7:0] reg_q, wdata_q;
    cmd_t       step_cmd, cmd_n, cmd_q;
    logic       accept, rsp_load, rsp_valid_n, abort_n;
    logic [7:0] rsp_rdata_n;
    logic       timer_clear, timer_en, timer_expire;
    logic       is_write_byte;

    assign is_write_byte = !(rnw_q && step_q == STEP_READ);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        step_cmd = CMD_NONE;
        case (step_q)
            STEP_ADDR: begin
                step_cmd.wr    = 1'b1;
                step_cmd.start = 1'b1;
                step_cmd.data  = {slave_q, 1'b0};
            end
            STEP_REG: begin
                step_cmd.wr   = 1'b1;
                step_cmd.data = reg_q;
            end
            STEP_XFER: begin
                step_cmd.wr = 1'b1;
                if (rnw_q) begin
                    step_cmd.start = 1'b1;
                    step_cmd.data  = {slave_q, 1'b1};
                end else begin
                    step_cmd.stop = 1'b1;
                    step_cmd.data = wdata_q;
                end
            end
            default: begin
                step_cmd.rd   = 1'b1;
                step_cmd.nack = 1'b1;
                step_cmd.stop = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_n     = state_q;
        step_n      = step_q;
        err_n       = err_q;
        cmd_n       = CMD_NONE;
        accept      = 1'b0;
        rsp_load    = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = 8'h00;
        abort_n     = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    accept  = 1'b1;
                    step_n  = STEP_ADDR;
                    err_n   = ERR_OK;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cmd_n       = step_cmd;
                timer_clear = 1'b1;
                state_n     = WAIT;
            end
            WAIT: begin
                timer_en = 1'b1;
                if (i_cmd_arb_lost) begin
                    // Bus is no longer ours, so no STOP is attempted.
                    err_n    = ERR_ARB;
                    rsp_load = 1'b1;
                    state_n  = RESP;
                end else if (i_cmd_done && i_cmd_slave_nack && is_write_byte) begin
                    err_n   = ERR_NACK;
                    state_n = STOP_ISSUE;
                end else if (i_cmd_done) begin
                    if (step_q == last_step(rnw_q)) begin
                        rsp_load    = 1'b1;
                        rsp_rdata_n = rnw_q ? i_cmd_rd_byte : 8'h00;
                        state_n     = RESP;
                    end else begin
                        step_n  = step_q + 2'd1;
                        state_n = ISSUE;
                    end
                end else if (timer_expire) begin
                    err_n    = ERR_TIMEOUT;
                    abort_n  = 1'b1;
                    rsp_load = 1'b1;
                    state_n  = RESP;
                end
            end
            STOP_ISSUE: begin
                cmd_n.stop  = 1'b1;
                timer_clear = 1'b1;
                state_n     = STOP_WAIT;
            end
            STOP_WAIT: begin
                timer_en = 1'b1;
                if (i_cmd_done) begin
                    rsp_load = 1'b1;
                    state_n  = RESP;
                end else if (timer_expire) begin
                    abort_n  = 1'b1;
                    rsp_load = 1'b1;
                    state_n  = RESP;
                end
            end
            RESP: begin
                rsp_valid_n = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    i2c_seq_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (timer_clear),
        .i_enable(timer_en),
        .o_expire(timer_expire)
    );

    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            step_q      <= STEP_ADDR;
            err_q       <= ERR_OK;
            cmd_q       <= CMD_NONE;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 8'h00;
            o_rsp_err   <= ERR_OK;
            o_bus_abort <= 1'b0;
            o_req_ready <= 1'b1;
        end else begin
            state_q     <= state_n;
            step_q      <= step_n;
            err_q       <= err_n;
            cmd_q       <= cmd_n;
            o_rsp_valid <= rsp_valid_n;
            o_bus_abort <= abort_n;
            o_req_ready <= (state_n == IDLE);
            // Response fields change only when a new response is formed.
            if (rsp_load) begin
                o_rsp_err   <= err_n;
                o_rsp_rdata <= rsp_rdata_n;
            end
        end
    end

    // NOTE: request fields are pure data captured on accept and never read before it, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            rnw_q   <= i_req_rnw;
            slave_q <= i_req_slave_addr;
            reg_q   <= i_req_reg_addr;
            wdata_q <= i_req_wdata;
        end
    end

    assign o_cmd_wr    = cmd_q.wr;
    assign o_cmd_rd    = cmd_q.rd;
    assign o_cmd_start = cmd_q.start;
    assign o_cmd_stop  = cmd_q.stop;
    assign o_cmd_nack  = cmd_q.nack;
    assign o_cmd_byte  = cmd_q.data;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: acts as the downstream byte master,
// checks command order/latency and every response code.
module tb_i2c_reg_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_req_rnw;
    logic [6:0] i_req_slave_addr;
    logic [7:0] i_req_reg_addr;
    logic [7:0] i_req_wdata;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_rdata;
    logic [1:0] o_rsp_err;
    logic       o_cmd_wr, o_cmd_rd, o_cmd_start, o_cmd_stop, o_cmd_nack;
    logic [7:0] o_cmd_byte;
    logic       i_cmd_done;
    logic       i_cmd_slave_nack;
    logic       i_cmd_arb_lost;
    logic [7:0] i_cmd_rd_byte;
    logic       o_bus_abort;

    logic [4:0] cmd_flags;
    logic       any_cmd;
    assign cmd_flags = {o_cmd_wr, o_cmd_rd, o_cmd_start, o_cmd_stop, o_cmd_nack};
    assign any_cmd   = o_cmd_wr | o_cmd_rd | o_cmd_stop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int req_cyc, done_cyc, cmd_cyc, rsp_cyc;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    i2c_reg_sequencer #(
        .TIMEOUT_CYCLES(16'd100)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_rnw       (i_req_rnw),
        .i_req_slave_addr(i_req_slave_addr),
        .i_req_reg_addr  (i_req_reg_addr),
        .i_req_wdata     (i_req_wdata),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_rdata     (o_rsp_rdata),
        .o_rsp_err       (o_rsp_err),
        .o_cmd_wr        (o_cmd_wr),
        .o_cmd_rd        (o_cmd_rd),
        .o_cmd_start     (o_cmd_start),
        .o_cmd_stop      (o_cmd_stop),
        .o_cmd_nack      (o_cmd_nack),
        .o_cmd_byte      (o_cmd_byte),
        .i_cmd_done      (i_cmd_done),
        .i_cmd_slave_nack(i_cmd_slave_nack),
        .i_cmd_arb_lost  (i_cmd_arb_lost),
        .i_cmd_rd_byte   (i_cmd_rd_byte),
        .o_bus_abort     (o_bus_abort)
    );

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic rnw, input logic [6:0] sa, input logic [7:0] ra,
                            input logic [7:0] wd);
        check("req_ready", o_req_ready, 1);
        i_req_valid      = 1'b1;
        i_req_rnw        = rnw;
        i_req_slave_addr = sa;
        i_req_reg_addr   = ra;
        i_req_wdata      = wd;
        req_cyc          = cyc;
        tick();
        i_req_valid = 1'b0;
        check("req_ready_drop", o_req_ready, 0);
    endtask

    // Waits (bounded) for the next command pulse; checks flags, byte, latency, width.
    task automatic expect_cmd(input string tag, input logic [4:0] exp_flags,
                              input logic [7:0] exp_byte, input logic chk_byte,
                              input int ref_cyc, input int exp_lat);
        int n = 0;
        while (!any_cmd && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_flags"}, cmd_flags, exp_flags);
        if (chk_byte) check({tag, "_byte"}, o_cmd_byte, exp_byte);
        check({tag, "_lat"}, cyc - ref_cyc, exp_lat);
        cmd_cyc = cyc;
        tick();
        check({tag, "_one_cycle"}, cmd_flags, 0);
    endtask

    task automatic give_done(input int delay, input logic nack, input logic [7:0] rd);
        repeat (delay) tick();
        i_cmd_done       = 1'b1;
        i_cmd_slave_nack = nack;
        i_cmd_rd_byte    = rd;
        done_cyc         = cyc;
        tick();
        i_cmd_done       = 1'b0;
        i_cmd_slave_nack = 1'b0;
        i_cmd_rd_byte    = 8'h00;
    endtask

    // Waits (bounded) for the response; no command may be issued meanwhile.
    task automatic expect_rsp(input string tag, input logic [1:0] exp_err,
                              input logic [7:0] exp_rdata, input int ref_cyc, input int exp_lat);
        int n = 0;
        int stray = 0;
        while (!o_rsp_valid && n < 300) begin
            tick();
            n++;
            if (any_cmd) stray++;
        end
        rsp_cyc = cyc;
        check({tag, "_rsp_valid"}, o_rsp_valid, 1);
        check({tag, "_rsp_err"}, o_rsp_err, exp_err);
        check({tag, "_rsp_rdata"}, o_rsp_rdata, exp_rdata);
        check({tag, "_no_cmd"}, stray, 0);
        check({tag, "_abort_low"}, o_bus_abort, 0);
        if (exp_lat >= 0) check({tag, "_rsp_lat"}, rsp_cyc - ref_cyc, exp_lat);
        tick();
        check({tag, "_rsp_one_cycle"}, o_rsp_valid, 0);
        check({tag, "_rsp_err_hold"}, o_rsp_err, exp_err);
        check({tag, "_ready_after"}, o_req_ready, 1);
    endtask

    task automatic run_write(input string tag, input logic [6:0] sa, input logic [7:0] ra,
                             input logic [7:0] wd);
        send_req(1'b0, sa, ra, wd);
        expect_cmd({tag, "_s0"}, 5'b10100, {sa, 1'b0}, 1'b1, req_cyc, 2);
        give_done(20, 1'b0, 8'hFF);
        expect_cmd({tag, "_s1"}, 5'b10000, ra, 1'b1, done_cyc, 2);
        give_done(20, 1'b0, 8'hFF);
        expect_cmd({tag, "_s2"}, 5'b10010, wd, 1'b1, done_cyc, 2);
        give_done(20, 1'b0, 8'hFF);
        expect_rsp(tag, 2'd0, 8'h00, done_cyc, 2);
    endtask

    task automatic run_read(input string tag, input logic [6:0] sa, input logic [7:0] ra,
                            input logic [7:0] rd);
        send_req(1'b1, sa, ra, 8'hEE);
        expect_cmd({tag, "_s0"}, 5'b10100, {sa, 1'b0}, 1'b1, req_cyc, 2);
        give_done(20, 1'b0, 8'hFF);
        expect_cmd({tag, "_s1"}, 5'b10000, ra, 1'b1, done_cyc, 2);
        give_done(20, 1'b0, 8'hFF);
        expect_cmd({tag, "_s2"}, 5'b10100, {sa, 1'b1}, 1'b1, done_cyc, 2);
        give_done(20, 1'b0, 8'hFF);
        expect_cmd({tag, "_s3"}, 5'b01011, 8'h00, 1'b1, done_cyc, 2);
        give_done(20, 1'b0, rd);
        expect_rsp(tag, 2'd0, rd, done_cyc, 2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int n;
        int quiet;
        i_rst            = 1'b1;
        i_req_valid      = 1'b0;
        i_req_rnw        = 1'b0;
        i_req_slave_addr = 7'h00;
        i_req_reg_addr   = 8'h00;
        i_req_wdata      = 8'h00;
        i_cmd_done       = 1'b0;
        i_cmd_slave_nack = 1'b0;
        i_cmd_arb_lost   = 1'b0;
        i_cmd_rd_byte    = 8'h00;
        repeat (3) tick();

        check("rst_ready", o_req_ready, 1);
        check("rst_cmd_flags", cmd_flags, 0);
        check("rst_cmd_byte", o_cmd_byte, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_rdata", o_rsp_rdata, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_abort", o_bus_abort, 0);
        i_rst = 1'b0;

        // Stray done while idle must be ignored.
        i_cmd_done = 1'b1;
        tick();
        i_cmd_done = 1'b0;
        repeat (3) tick();
        check("idle_done_no_rsp", o_rsp_valid, 0);
        check("idle_done_no_cmd", cmd_flags, 0);
        check("idle_done_ready", o_req_ready, 1);

        run_write("wr", 7'h3C, 8'h10, 8'hA5);
        run_read("rd", 7'h50, 8'h02, 8'h5A);

        // Slave NACKs the register byte: STOP-only command, then err 1.
        send_req(1'b0, 7'h3C, 8'h10, 8'h77);
        expect_cmd("nk_s0", 5'b10100, 8'h78, 1'b1, req_cyc, 2);
        give_done(20, 1'b0, 8'h00);
        expect_cmd("nk_s1", 5'b10000, 8'h10, 1'b1, done_cyc, 2);
        give_done(20, 1'b1, 8'h00);
        expect_cmd("nk_stop", 5'b00010, 8'h00, 1'b0, done_cyc, 2);
        give_done(20, 1'b0, 8'h00);
        expect_rsp("nk", 2'd1, 8'h00, done_cyc, 2);

        // Arbitration lost during read step 2: no STOP, err 2 within 2 cycles.
        send_req(1'b1, 7'h50, 8'h02, 8'h00);
        expect_cmd("arb_s0", 5'b10100, 8'hA0, 1'b1, req_cyc, 2);
        give_done(20, 1'b0, 8'h00);
        expect_cmd("arb_s1", 5'b10000, 8'h02, 1'b1, done_cyc, 2);
        give_done(20, 1'b0, 8'h00);
        expect_cmd("arb_s2", 5'b10100, 8'hA1, 1'b1, done_cyc, 2);
        repeat (5) tick();
        i_cmd_arb_lost = 1'b1;
        done_cyc       = cyc;
        tick();
        i_cmd_arb_lost = 1'b0;
        expect_rsp("arb", 2'd2, 8'h00, done_cyc, -1);
        check("arb_rsp_within_2", (rsp_cyc - done_cyc) <= 2, 1);

        // No done at all: abort and err 3 exactly 100 cycles after the step-0 pulse.
        send_req(1'b0, 7'h22, 8'h05, 8'h99);
        expect_cmd("to_s0", 5'b10100, 8'h44, 1'b1, req_cyc, 2);
        n = 0;
        while (!o_bus_abort && n < 300) begin
            tick();
            n++;
        end
        check("to_abort", o_bus_abort, 1);
        check("to_abort_lat", cyc - cmd_cyc, 100);
        check("to_abort_err", o_rsp_err, 3);
        expect_rsp("to", 2'd3, 8'h00, cmd_cyc, 101);
        run_read("post_to", 7'h11, 8'h20, 8'hC3);

        // Reset during step-1 WAIT: everything clears, no response appears.
        send_req(1'b0, 7'h3C, 8'h10, 8'hA5);
        expect_cmd("rs_s0", 5'b10100, 8'h78, 1'b1, req_cyc, 2);
        give_done(20, 1'b0, 8'h00);
        expect_cmd("rs_s1", 5'b10000, 8'h10, 1'b1, done_cyc, 2);
        repeat (5) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("rs_cmd_flags", cmd_flags, 0);
        check("rs_cmd_byte", o_cmd_byte, 0);
        check("rs_rsp_valid", o_rsp_valid, 0);
        check("rs_rsp_rdata", o_rsp_rdata, 0);
        check("rs_rsp_err", o_rsp_err, 0);
        check("rs_abort", o_bus_abort, 0);
        check("rs_ready", o_req_ready, 1);
        quiet = 0;
        repeat (3) begin
            tick();
            if (o_rsp_valid || any_cmd) quiet++;
        end
        check("rs_no_activity", quiet, 0);
        run_write("post_rs", 7'h3C, 8'h10, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
